// File: rtl/sample_cdc_receiver_pkg.sv
// Shared defaults, FSM state type and width helper
// for the toggle-handshake sample receiver.
package sample_cdc_pkg;

  localparam int DATA_W      = 12;
  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_cdc_receiver_if.sv
// Source handshake and FWFT consumer bundle
// of the sample receiver.
interface sample_cdc_receiver_if #(
  parameter int DATA_W     = sample_cdc_pkg::DATA_W,
  parameter int FIFO_DEPTH = sample_cdc_pkg::FIFO_DEPTH
);
  import sample_cdc_pkg::*;

  localparam int LW = lvl_w(FIFO_DEPTH);

  logic              src_req;
  logic [DATA_W-1:0] src_data;
  logic              dst_ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LW-1:0]     level;
  logic [15:0]       words_rcvd;

  modport slave (
    input  src_req,
    input  src_data,
    input  out_ready,
    output dst_ack,
    output out_valid,
    output out_data,
    output level,
    output words_rcvd
  );

  modport master (
    output src_req,
    output src_data,
    output out_ready,
    input  dst_ack,
    input  out_valid,
    input  out_data,
    input  level,
    input  words_rcvd
  );

endinterface

// File: rtl/sample_cdc_receiver_fifo.sv
// First-word-fall-through synchronous FIFO
// with occupancy level.
module sample_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr,
  input  logic [DATA_W-1:0]               i_wdata,
  input  logic                            i_pop,
  output logic [DATA_W-1:0]               o_rdata,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [sample_cdc_pkg::lvl_w(DEPTH)-1:0] o_level
);
  import sample_cdc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign w_pop   = i_pop && !o_empty;
  // Head word is zeroed while empty so reset shows 0.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({i_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sample_cdc_receiver.sv
// Toggle req/ack CDC receiver: sync, capture,
// ack, buffer; backpressure by withholding ack.
module sample_cdc_receiver #(
  parameter int DATA_W      = sample_cdc_pkg::DATA_W,
  parameter int SYNC_STAGES = sample_cdc_pkg::SYNC_STAGES,
  parameter int FIFO_DEPTH  = sample_cdc_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sample_cdc_receiver_if.slave bus
);
  import sample_cdc_pkg::*;

  localparam int LW = lvl_w(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_seen;
  logic                   r_ack;
  logic [15:0]            r_words;
  state_t                 r_state;
  state_t                 w_state_n;

  logic              w_req_sync;
  logic              w_pending;
  logic              w_pop;
  logic              w_can_write;
  logic              w_wr;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rdata;
  logic [LW-1:0]     w_level;

  assign w_req_sync  = r_sync[SYNC_STAGES-1];
  assign w_pending   = w_req_sync ^ r_req_seen;
  assign w_pop       = !w_empty && bus.out_ready;
  // A pop in the same cycle frees the slot for the write.
  assign w_can_write = !w_full || w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], bus.src_req};
  end

  always_comb begin
    w_state_n = r_state;
    w_wr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pending) begin
          if (w_can_write) w_wr      = 1'b1;
          else             w_state_n = STALL;
        end
      end
      STALL: begin
        if (w_pending && w_can_write) begin
          w_wr      = 1'b1;
          w_state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_wr) begin
        r_req_seen <= w_req_sync;
        r_ack      <= ~r_ack;
        r_words    <= r_words + 16'd1;
      end
    end
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_wr    (w_wr),
    .i_wdata (bus.src_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.dst_ack    = r_ack;
  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = w_rdata;
  assign bus.level      = w_level;
  assign bus.words_rcvd = r_words;

endmodule

// File: tb/tb_sample_cdc_receiver.sv
// Randomized self-checking bench for sample_cdc_receiver
// against a queue-based handshake model.
module tb_sample_cdc_receiver;

  localparam int DW    = 12;
  localparam int SS    = 2;
  localparam int DEPTH = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  sample_cdc_receiver_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  sample_cdc_receiver #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nchecks = 0;
  int nfail   = 0;

  bit            rq[$];
  logic [DW-1:0] mq[$];
  logic          m_ack   = 1'b0;
  logic [15:0]   m_cnt   = '0;
  logic          preload = 1'b0;

  logic [DW-1:0] pop_log[$];
  logic [DW-1:0] sent[$];
  bit            rand_ready = 1'b0;
  int            base;
  logic [DW-1:0] w;

  // Receiver sees src_req SS edges late; accepts when it
  // differs from ack and a slot is (or is being) freed.
  always @(posedge clk or negedge reset_n) begin
    bit vis;
    bit popm;
    bit acc;
    if (!reset_n) begin
      rq = {};
      for (int i = 0; i < SS; i++) rq.push_back(1'b0);
      mq    = {};
      m_ack = 1'b0;
      m_cnt = '0;
    end else begin
      vis = rq.pop_front();
      rq.push_back(bus.src_req);
      if (preload) m_cnt = 16'hFFFE;
      popm = (mq.size() != 0) && bus.out_ready;
      acc  = (vis != m_ack) && ((mq.size() < DEPTH) || popm);
      if (popm) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(bus.src_data);
        m_ack = ~m_ack;
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (bus.dst_ack !== bus.src_req && n < 40) begin
      step();
      n++;
    end
    chk(nm, 32'(bus.dst_ack), 32'(bus.src_req));
  endtask

  task automatic toggle(input logic [DW-1:0] d);
    bus.src_data = d;
    bus.src_req  = ~bus.src_req;
  endtask

  task automatic send(input logic [DW-1:0] d);
    toggle(d);
    step();
    wait_ack("ack_timeout");
  endtask

  task automatic do_reset();
    bus.src_req = 1'b0;
    reset_n     = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    bus.src_req   = 1'b0;
    bus.src_data  = '0;
    bus.out_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        chk("m_ack", 32'(bus.dst_ack), 32'(m_ack));
        chk("m_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(bus.level), 32'(mq.size()));
        chk("m_data", 32'(bus.out_data),
            (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_cnt", 32'(bus.words_rcvd), 32'(m_cnt));
        if (bus.out_valid && bus.out_ready) pop_log.push_back(bus.out_data);
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      end
      begin
        repeat (3) step();
        chk("rst_ack", 32'(bus.dst_ack), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_cnt", 32'(bus.words_rcvd), 0);
        reset_n = 1'b1;
        step();

        bus.out_ready = 1'b1;
        toggle(12'hA5C);
        step();
        step();
        chk("one_ack_e1", 32'(bus.dst_ack), 0);
        step();
        chk("one_ack_e2", 32'(bus.dst_ack), 1);
        chk("one_valid", 32'(bus.out_valid), 1);
        chk("one_data", 32'(bus.out_data), 32'h0A5C);
        chk("one_cnt", 32'(bus.words_rcvd), 1);
        repeat (3) step();

        do_reset();
        bus.out_ready = 1'b1;
        base = pop_log.size();
        for (int i = 1; i <= 10; i++) send(DW'(i));
        repeat (4) step();
        chk("burst_n", 32'(pop_log.size() - base), 10);
        for (int i = 0; i < 10; i++)
          chk("burst_ord", 32'(pop_log[base+i]), 32'(i + 1));
        chk("burst_cnt", 32'(bus.words_rcvd), 10);

        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(DW'(12'h100 + i));
        toggle(12'h105);
        repeat (6) step();
        chk("bp_level", 32'(bus.level), 4);
        chk("bp_stall", 32'(bus.dst_ack ^ bus.src_req), 1);
        chk("bp_cnt4", 32'(bus.words_rcvd), 4);
        base = pop_log.size();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_ack", 32'(bus.dst_ack ^ bus.src_req), 0);
        chk("bp_full", 32'(bus.level), 4);
        chk("bp_cnt5", 32'(bus.words_rcvd), 5);
        bus.out_ready = 1'b1;
        repeat (8) step();
        chk("bp_n", 32'(pop_log.size() - base), 5);
        for (int i = 0; i < 5; i++)
          chk("bp_ord", 32'(pop_log[base+i]), 32'(12'h101 + i));

        do_reset();
        sent = {};
        base = pop_log.size();
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
          w = DW'($urandom);
          sent.push_back(w);
          send(w);
          repeat ($urandom_range(0, 3)) step();
        end
        rand_ready = 1'b0;
        step();
        bus.out_ready = 1'b1;
        repeat (8) step();
        chk("rnd_n", 32'(pop_log.size() - base), 32'(sent.size()));
        for (int i = 0; i < sent.size(); i++)
          if (base + i < pop_log.size())
            chk("rnd_ord", 32'(pop_log[base+i]), 32'(sent[i]));

        preload = 1'b1;
        step();
        force dut.r_words = 16'hFFFE;
        preload = 1'b0;
        step();
        release dut.r_words;
        step();
        chk("wrap_pre", 32'(bus.words_rcvd), 32'hFFFE);
        send(12'h3C3);
        chk("wrap_ffff", 32'(bus.words_rcvd), 32'hFFFF);
        send(12'h5A5);
        chk("wrap_zero", 32'(bus.words_rcvd), 0);
        repeat (3) step();

        do_reset();
        bus.out_ready = 1'b0;
        send(12'h111);
        send(12'h222);
        toggle(12'h333);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_ack", 32'(bus.dst_ack), 0);
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_level", 32'(bus.level), 0);
        chk("mid_cnt", 32'(bus.words_rcvd), 0);
        chk("mid_data", 32'(bus.out_data), 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        wait_ack("rel_pend");
        chk("rel_cnt", 32'(bus.words_rcvd), 1);
        chk("rel_level", 32'(bus.level), 1);
        chk("rel_data", 32'(bus.out_data), 32'h0333);
        repeat (3) step();
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/sample_cdc_receiver.md
Name: sample_cdc_receiver

Overview:
- Destination-side receiver for a 2-phase (toggle) req/ack handshake that carries ADC sample words from a foreign clock domain into the `clk` domain.
- It synchronizes the incoming request toggle, captures the held data word, and returns an acknowledge toggle.
- Captured words are buffered in a small FWFT FIFO with a valid/ready output toward the Nios/Qsys-side consumer.
- Backpressure is applied by withholding ack, so no sample is ever lost.

Parameters:
- DATA_W, 12, sample word width.
- SYNC_STAGES, 2, flops in the src_req synchronizer chain; legal values >= 2.
- FIFO_DEPTH, 4, buffer entries; must be a power of two and >= 2.

Ports:
- clk  in  1  single destination clock.
- reset_n  in  1  asynchronous active-low reset.
- src_req  in  1  request toggle from the foreign domain; asynchronous to clk.
- src_data  in  DATA_W  sample word; the source holds it stable whenever src_req != dst_ack.
- dst_ack  out  1  acknowledge toggle, registered; the source synchronizes it.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  head-of-FIFO word (FWFT).
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- words_rcvd  out  16  count of words accepted from the source; wraps at 2^16.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - Synchronizer flops, req_seen, dst_ack, FIFO pointers, level and words_rcvd are all cleared to 0.
  - out_valid = 0 and out_data = 0.
- Synchronizer: src_req passes through SYNC_STAGES flops to give req_sync. Only req_sync is used; src_req itself is never sampled combinationally.
- Pending condition: pending = (req_sync != req_seen).
- FSM, 2 states:
  - IDLE: when pending && can_write, at one edge: write src_data to the FIFO, toggle dst_ack, set req_seen = req_sync, increment words_rcvd, stay in IDLE.
  - IDLE: when pending && !can_write, go to STALL.
  - STALL: hold dst_ack, write nothing; return to IDLE (with the write) on the first cycle can_write = 1.
- can_write = !full || (out_valid && out_ready). A simultaneous pop frees the slot in the same cycle.
- Latency with SYNC_STAGES = 2 and the FIFO not full:
  - src_req toggles before edge k.
  - req_sync changes after edge k+1.
  - Write and dst_ack toggle occur at edge k+2.
  - out_valid is high after edge k+2 if the FIFO was empty.
- Throughput: at most one word per full handshake round trip. A second toggle never arrives before dst_ack toggles.
- FIFO behaviour:
  - FWFT: out_data is valid whenever out_valid = 1.
  - A pop happens on out_valid && out_ready.
  - out_ready while empty has no effect.
  - level is +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - Never overflows: a write is only issued under can_write.
- Width rules:
  - words_rcvd wraps from 16'hFFFF to 0 without a flag.
  - level reaches FIFO_DEPTH when full.
- Reset mid-handshake:
  - All state is cleared. A word in flight is discarded.
  - If src_req = 1 at reset release, the mismatch with req_seen = 0 is treated as a new pending word. The source must be reset in the same reset domain.
- Glitch rule: src_data is only captured in the write cycle, which is at least SYNC_STAGES clk edges after the req toggle. This provides the settle margin.

Decomposition:
- Package sample_cdc_pkg holds:
  - the default constants (DATA_W, SYNC_STAGES, FIFO_DEPTH);
  - the FSM state enum {IDLE, STALL};
  - a level-width function.
- One sub-module, sample_fifo: parameterised FWFT synchronous FIFO with write, pop, full, empty and level.
- The synchronizer and FSM stay in the top level.

Test Plan:
- Reset: hold reset_n = 0 with src_req = 0 -> dst_ack = 0, out_valid = 0, level = 0, words_rcvd = 0; assert mid-transfer -> all cleared immediately.
- Single word: src_data = 12'hA5C, toggle src_req before edge 0, out_ready = 1 -> dst_ack toggles at edge 2; out_valid with out_data = 12'hA5C after edge 2; words_rcvd = 1.
- Burst with a behavioural source model (waits for ack): send 12'h001..12'h00A with out_ready = 1 -> output order 001..00A, no duplicates, words_rcvd = 10.
- Backpressure: out_ready = 0, send 5 words with FIFO_DEPTH = 4 -> level = 4; 5th dst_ack withheld (FSM in STALL); one pop -> 5th word written and acked on that cycle; level stays 4.
- Simultaneous write and pop when full: level = 4, pending word, out_valid && out_ready -> write accepted the same cycle, level = 4, FIFO data order preserved.
- Counter wrap: preload via 65536 transfers (or force) -> words_rcvd goes 16'hFFFF to 0 with no side effects on data or ack.
